// File: rtl/shift_register_4b.sv
// Four-stage serial-in shift register: A enters B and moves on through C and D to E.
// B, C and D are the parallel taps and E is the serial output.
module shift_register_4b #(
  parameter logic [3:0] RESET_VAL = 4'b0000
) (
  input  logic clk,
  input  logic clr,
  input  logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E
);

  // All four stages update on the same edge. clr takes priority over A.
  always_ff @(posedge clk) begin
    if (clr) begin
      B <= RESET_VAL[3];
      C <= RESET_VAL[2];
      D <= RESET_VAL[1];
      E <= RESET_VAL[0];
    end else begin
      B <= A;
      C <= B;
      D <= C;
      E <= D;
    end
  end

endmodule

// File: tb/tb_shift_register_4b.sv
// Self-checking bench for shift_register_4b. It drives two instances with the same stimulus:
// one with the default reset value and one with RESET_VAL=4'b1010.
module tb_shift_register_4b;

  localparam logic [3:0] RV_ALT = 4'b1010;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic a   = 1'b0;
  logic b0, c0, d0, e0;
  logic b1, c1, d1, e1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: a queue of the bits in flight for each instance, newest bit first.
  logic q0[$];
  logic q1[$];

  shift_register_4b u_dut0 (
    .clk (clk), .clr (clr), .A (a),
    .B (b0), .C (c0), .D (d0), .E (e0)
  );

  shift_register_4b #(.RESET_VAL(RV_ALT)) u_dut1 (
    .clk (clk), .clr (clr), .A (a),
    .B (b1), .C (c1), .D (d1), .E (e1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] q_taps(input logic q[$]);
    return {q[0], q[1], q[2], q[3]};
  endfunction

  // Apply one edge, update the model from the rules, then compare both instances.
  task automatic step(input logic ain, input logic cin, input string tag);
    a   = ain;
    clr = cin;
    @(posedge clk);
    if (cin) begin
      q0.delete();
      q1.delete();
      for (int i = 3; i >= 0; i--) begin
        q0.push_back(1'b0);
        q1.push_back(RV_ALT[i]);
      end
    end else begin
      q0.push_front(ain);
      void'(q0.pop_back());
      q1.push_front(ain);
      void'(q1.pop_back());
    end
    #1;
    check({tag, ".def"}, {b0, c0, d0, e0}, q_taps(q0));
    check({tag, ".alt"}, {b1, c1, d1, e1}, q_taps(q1));
  endtask

  initial begin
    logic [3:0] pat;
    logic ar;
    logic cr;

    #2;
    // Reset is held for two edges with A=1. The outputs must stay at the reset value.
    step(1'b1, 1'b1, "reset1");
    check("reset1.zero", {b0, c0, d0, e0}, 4'b0000);
    check("reset1.rv", {b1, c1, d1, e1}, 4'b1010);
    step(1'b1, 1'b1, "reset2");
    check("reset2.zero", {b0, c0, d0, e0}, 4'b0000);

    // A single 1 must walk through B, C, D and E.
    step(1'b1, 1'b0, "pulse0");
    check("pulse.B", {b0, c0, d0, e0}, 4'b1000);
    step(1'b0, 1'b0, "pulse1");
    check("pulse.C", {b0, c0, d0, e0}, 4'b0100);
    step(1'b0, 1'b0, "pulse2");
    check("pulse.D", {b0, c0, d0, e0}, 4'b0010);
    step(1'b0, 1'b0, "pulse3");
    check("pulse.E", {b0, c0, d0, e0}, 4'b0001);
    step(1'b0, 1'b0, "pulse4");
    check("pulse.clear", {b0, c0, d0, e0}, 4'b0000);
    check("alt.shift0", {b1, c1, d1, e1}, 4'b0000);

    // Pattern 0,0,1,1, then two further edges with A=1.
    pat = 4'b0011;
    for (int i = 3; i >= 0; i--) step(pat[i], 1'b0, "pat");
    check("pat.0011", {b0, c0, d0, e0}, 4'b1100);
    step(1'b1, 1'b0, "pat5");
    step(1'b1, 1'b0, "pat6");
    check("pat.ones", {b0, c0, d0, e0}, 4'b1111);

    // Alternating input for 8 edges.
    for (int i = 0; i < 8; i++) begin
      step(1'(i % 2 == 0), 1'b0, "alt");
      if (i >= 3) check("alt.nonequal", {b0 ^ c0, c0 ^ d0, d0 ^ e0, 1'b0}, 4'b1110);
    end

    // Reset in the middle of a stream of ones.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "load");
    check("mid.load", {b0, c0, d0, e0}, 4'b1111);
    step(1'b1, 1'b1, "mid.clr");
    check("mid.zero", {b0, c0, d0, e0}, 4'b0000);
    step(1'b1, 1'b0, "mid.resume");
    check("mid.resume_b", {b0, c0, d0, e0}, 4'b1000);
    check("mid.resume_alt", {b1, c1, d1, e1}, 4'b1101);

    // Random stream with an occasional reset edge.
    for (int i = 0; i < 300; i++) begin
      ar = 1'($urandom_range(0, 1));
      cr = ($urandom_range(0, 15) == 0);
      step(ar, cr, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_register_4b.md
Name: shift_register_4b

Overview:
- 4-stage serial-in, parallel/serial-out shift register.
- Serial data enters on A and advances one stage per rising clock edge through B -> C -> D -> E.
- E is the serial output, delayed 4 cycles from A; B, C and D are the intermediate stage taps.
- Used as a simple delay line / serial-to-parallel converter in small datapaths.

Parameters:
- RESET_VAL, 4'b0000: value loaded into stages {B,C,D,E} on reset. Bit 3 loads B, bit 0 loads E.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous reset, active-high.
- A    input  1  serial data in.
- B    output 1  stage 1; A delayed 1 cycle.
- C    output 1  stage 2; A delayed 2 cycles.
- D    output 1  stage 3; A delayed 3 cycles.
- E    output 1  stage 4 / serial out; A delayed 4 cycles.
- Port order in the module header: clk, clr, A, B, C, D, E. Instances connect positionally in this order.

Behaviour:
- Single clock domain: clk, rising edge only. No asynchronous paths.
- Reset: clr sampled high at a rising edge loads B=RESET_VAL[3], C=RESET_VAL[2], D=RESET_VAL[1], E=RESET_VAL[0]. Default gives all outputs 0.
- Reset takes effect at the edge, not before. Outputs are undefined from power-up until the first edge with clr=1.
- Normal operation, clr low at a rising edge, all stages update simultaneously:
  - B <= A
  - C <= B (old value)
  - D <= C (old value)
  - E <= D (old value)
- Latency: a value on A at edge n appears on B after edge n, on C after n+1, on D after n+2, on E after n+3. Equivalently, E at edge n+3 equals A sampled at edge n; total 4 register stages.
- Every stage is updated every cycle. There is no enable and no hold.
- Reset priority: clr high overrides A on the same edge. The value on A at a reset edge is discarded.
- Reset mid-stream: all in-flight bits are lost. Shifting resumes on the first edge with clr low, with B taking A.
- Outputs are registered directly, with no combinational path from A or clr to any output.
- Unknown (X) on A propagates stage by stage like data. A reset clears it.
- Registers must be implemented with non-blocking assignments so stages do not collapse into one.

Test Plan:
- Reset: hold clr=1 for 2 edges with A=1 -> B=C=D=E=0 after the first edge and they stay 0.
- Single pulse: release clr, drive A=1 for one cycle then A=0 -> 1 walks B, C, D, E on consecutive edges (B=1 at edge 1, E=1 at edge 4), then all return to 0.
- Pattern 0,0,1,1 on A over 4 edges from cleared state -> after edge 4, {B,C,D,E}={1,1,0,0}. Two further edges with A=1 -> {1,1,1,1}.
- Alternating A=1,0,1,0,... for 8 edges -> after every edge B!=C, C!=D, D!=E, and E(n) = A(n-4).
- Mid-stream reset: load {1,1,1,1}, assert clr for 1 edge with A=1 -> {0,0,0,0}. Deassert with A=1 -> B=1, C=D=E=0 after the next edge.
- RESET_VAL=4'b1010 variant: after a reset edge -> B=1, C=0, D=1, E=0. Then shifting A=0 for 4 edges -> all 0.
